nubus_master: RTL
=================

// Module: nubus_master
// PURPOSE
//  NuBus master sequencer. Takes one local transfer request and requests the
//  bus with the card's slot ID. It arbitrates, waits for the bus to go idle,
//  then drives the START cycle and waits for ACK or a timeout.
//  Its mstdn_o output feeds the mstdn input of the slave controller, which
//  then clears the master flag.
// PARAMETERS
//  ARB_SETTLE  2    clocks of RQST/ARB drive before the ARB lines are compared
//  TIMEOUT     255  clocks in DATA without ACK before the transfer is aborted
//  TO_W        8    timeout counter width; must hold TIMEOUT
// PORTS
//  nub_clkn     in   1  bus clock; all logic on posedge
//  reset        in   1  asynchronous, active-high reset
//  nub_idn      in   4  slot ID, active-low, static
//  nub_arbn     in   4  sampled ARB lines, active-low, wired-OR
//  nub_rqstn    in   1  sampled bus RQST, active-low
//  nub_startn   in   1  sampled bus START, active-low
//  nub_ackn     in   1  sampled bus ACK, active-low
//  nub_tm1n     in   1  sampled TM1; carries the ACK status
//  nub_tm0n     in   1  sampled TM0; carries the ACK status
//  mst_req      in   1  local transfer request; level, held until mst_done_o
//  slave_busy   in   1  own slave cycle active; inhibits START
//  rqst_o       out  1  drive RQST low
//  arb_o        out  4  per-bit drive enables: bit=1 drives ARB[i] low (from ~nub_idn)
//  start_o      out  1  drive START low
//  ad_oe_o      out  1  enable address/TM drivers; same cycle as start_o
//  mst_busy_o   out  1  high from win until DONE
//  mstdn_o      out  1  one-clock pulse at end of the master cycle
//  mst_done_o   out  1  same pulse as mstdn_o, for the local side
//  mst_timeout_o out 1  one-clock pulse, coincident with mst_done_o, on abort
//  mst_status_o out  2  ~{tm1n,tm0n} latched at ACK; 2'b11 on timeout
// BEHAVIOUR
//  Reset (asynchronous)
//  - State goes to IDLE.
//  - Every output goes to 0, including mst_status_o.
//  - The fairness lock and bus_busy are cleared.
//  - A reset mid-transfer releases RQST/ARB/START on the reset edge; there is
//    no completion pulse.
//  bus_busy (bus monitor)
//  - Set on a clock with start=~nub_startn=1 and ack=~nub_ackn=0.
//  - Cleared on a clock with ack=1.
//  - If START and ACK are seen on the same clock, bus_busy is cleared.
//  Fairness lock
//  - Set at DONE.
//  - Cleared on any clock with nub_rqstn=1.
//  - While set, IDLE does not leave for REQ.
//  States
//  - IDLE: wait for mst_req & ~lock, then go to REQ.
//  - REQ: rqst_o=1, arb_o=~nub_idn. Count ARB_SETTLE clocks, then go to CMP.
//    If mst_req drops, go to IDLE.
//  - CMP: if nub_arbn==nub_idn the card has won: go to WAITIDLE and set
//    mst_busy_o. Otherwise clear arb_o, keep rqst_o, and go back to REQ once
//    the bus is idle (bus_busy=0 and nub_rqstn observed deasserted-or-idle);
//    re-arbitration starts on the next ~bus_busy edge. If mst_req drops,
//    go to IDLE.
//  - WAITIDLE: RQST/ARB are held. Go to START when ~bus_busy & ~slave_busy
//    & ~start. mst_req is now ignored; a won transfer always completes.
//  - START: exactly 1 clock with start_o=1 and ad_oe_o=1. RQST and ARB are
//    released in this cycle. Go to DATA; the timeout counter is cleared.
//  - DATA: wait for ack=1, then latch mst_status_o from TM and go to DONE.
//    If the counter reaches TIMEOUT, go to DONE with mst_timeout_o=1 and
//    mst_status_o=2'b11.
//  - DONE: 1 clock with mstdn_o=mst_done_o=1. mst_busy_o clears on the next
//    clock. Set the lock, go to IDLE.
//  Latency
//  - Request to START with an idle, uncontested bus:
//    1 (IDLE) + ARB_SETTLE + 1 (CMP) + 1 (WAITIDLE) clocks.
//  - Minimum transfer: START + DATA(ack on first clock) + DONE = 3 clocks.
//  Counter rules
//  - The timeout counter saturates at TIMEOUT and never wraps.
//  - The ARB_SETTLE counter reloads on every entry to REQ.
// TESTING
//  1. idn=4'h0 (ID F), idle bus, mst_req=1
//     -> rqst_o/arb_o=4'hF for 2 clks
//     -> start_o pulse at clk 5
//     -> ack with tm=01 at clk 6 -> mst_status_o=2'b10, mstdn_o pulse at clk 7.
//  2. nub_arbn forced to 4'h0 (higher ID wins) in CMP
//     -> arb_o=0, no start_o
//     -> release arbn to idn after the other START/ACK -> win, START issued.
//  3. Won, no ACK for 255 clocks
//     -> mst_timeout_o=mst_done_o=1, mst_status_o=2'b11, back to IDLE,
//        bus outputs 0.
//  4. mst_req stays 1 after DONE, nub_rqstn held 0
//     -> no new REQ; raise nub_rqstn 1 clk -> REQ entered next clock.
//  5. Assert reset in DATA
//     -> all outputs 0 asynchronously, no mstdn_o; after release with
//        mst_req=0 -> stays IDLE.
//  6. Won, slave_busy=1 for 10 clks
//     -> start_o held off; start_o on the 1st clock after slave_busy falls.

Source files
------------

// File: rtl/nubus_master_if.sv
// Bus-side and local handshake signals of the NuBus master sequencer.
// The master modport faces the sequencer; the slave modport faces whatever drives it.
interface nubus_master_if;
    logic [3:0] nub_idn;
    logic [3:0] nub_arbn;
    logic       nub_rqstn;
    logic       nub_startn;
    logic       nub_ackn;
    logic       nub_tm1n;
    logic       nub_tm0n;
    logic       mst_req;
    logic       slave_busy;
    logic       rqst_o;
    logic [3:0] arb_o;
    logic       start_o;
    logic       ad_oe_o;
    logic       mst_busy_o;
    logic       mstdn_o;
    logic       mst_done_o;
    logic       mst_timeout_o;
    logic [1:0] mst_status_o;

    modport master (
        input  nub_idn, nub_arbn, nub_rqstn, nub_startn, nub_ackn,
               nub_tm1n, nub_tm0n, mst_req, slave_busy,
        output rqst_o, arb_o, start_o, ad_oe_o, mst_busy_o, mstdn_o,
               mst_done_o, mst_timeout_o, mst_status_o
    );

    modport slave (
        output nub_idn, nub_arbn, nub_rqstn, nub_startn, nub_ackn,
               nub_tm1n, nub_tm0n, mst_req, slave_busy,
        input  rqst_o, arb_o, start_o, ad_oe_o, mst_busy_o, mstdn_o,
               mst_done_o, mst_timeout_o, mst_status_o
    );
endinterface

// File: rtl/nubus_master.sv
// NuBus master sequencer: arbitrates with the slot ID, waits for an idle bus,
// drives one START cycle, then waits for ACK or aborts on timeout.
module nubus_master #(
    parameter int ARB_SETTLE = 2,
    parameter int TIMEOUT    = 255,
    parameter int TO_W       = 8
) (
    input  logic              nub_clkn,
    input  logic              reset,
    nubus_master_if.master    bus
);
    localparam int SW = (ARB_SETTLE > 1) ? $clog2(ARB_SETTLE) : 1;

    typedef enum logic [2:0] {
        IDLE, REQ, CMP, WAITIDLE, START, DATA, DONE
    } state_t;

    state_t          state;
    logic [SW-1:0]   settle_cnt;
    logic [TO_W-1:0] to_cnt;
    logic            bus_busy;
    logic            lock;
    logic            lost;
    logic            seen_busy;

    wire start_seen = ~bus.nub_startn;
    wire ack_seen   = ~bus.nub_ackn;

    // Bus monitor: a START opens a transaction, any ACK closes it.
    // NOTE: state registers use non-blocking assignments so every block sees pre-edge values.
    always_ff @(posedge nub_clkn or posedge reset) begin
        if (reset)           bus_busy <= 1'b0;
        else if (ack_seen)   bus_busy <= 1'b0;
        else if (start_seen) bus_busy <= 1'b1;
    end

    always_ff @(posedge nub_clkn or posedge reset) begin
        if (reset)               lock <= 1'b0;
        else if (state == DONE)  lock <= 1'b1;
        else if (bus.nub_rqstn)  lock <= 1'b0;
    end

    always_ff @(posedge nub_clkn or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            settle_cnt        <= '0;
            to_cnt            <= '0;
            lost              <= 1'b0;
            seen_busy         <= 1'b0;
            bus.rqst_o        <= 1'b0;
            bus.arb_o         <= 4'h0;
            bus.start_o       <= 1'b0;
            bus.ad_oe_o       <= 1'b0;
            bus.mst_busy_o    <= 1'b0;
            bus.mstdn_o       <= 1'b0;
            bus.mst_done_o    <= 1'b0;
            bus.mst_timeout_o <= 1'b0;
            bus.mst_status_o  <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.mst_req && !lock) begin
                        state      <= REQ;
                        settle_cnt <= '0;
                        bus.rqst_o <= 1'b1;
                        bus.arb_o  <= ~bus.nub_idn;
                    end
                end
                REQ: begin
                    if (!bus.mst_req) begin
                        state      <= IDLE;
                        bus.rqst_o <= 1'b0;
                        bus.arb_o  <= 4'h0;
                    end else if (settle_cnt == SW'(ARB_SETTLE - 1)) begin
                        state <= CMP;
                        lost  <= 1'b0;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                CMP: begin
                    if (!bus.mst_req) begin
                        state      <= IDLE;
                        lost       <= 1'b0;
                        bus.rqst_o <= 1'b0;
                        bus.arb_o  <= 4'h0;
                    end else if (!lost) begin
                        if (bus.nub_arbn == bus.nub_idn) begin
                            state          <= WAITIDLE;
                            bus.mst_busy_o <= 1'b1;
                        end else begin
                            lost      <= 1'b1;
                            seen_busy <= 1'b0;
                            bus.arb_o <= 4'h0;
                        end
                    end else begin
                        // Re-arbitrate only after the winner's transaction has come and gone.
                        if (bus_busy) seen_busy <= 1'b1;
                        if (seen_busy && !bus_busy) begin
                            state      <= REQ;
                            lost       <= 1'b0;
                            settle_cnt <= '0;
                            bus.arb_o  <= ~bus.nub_idn;
                        end
                    end
                end
                WAITIDLE: begin
                    if (!bus_busy && !bus.slave_busy && !start_seen) begin
                        state       <= START;
                        to_cnt      <= '0;
                        bus.start_o <= 1'b1;
                        bus.ad_oe_o <= 1'b1;
                        bus.rqst_o  <= 1'b0;
                        bus.arb_o   <= 4'h0;
                    end
                end
                START: begin
                    state       <= DATA;
                    to_cnt      <= '0;
                    bus.start_o <= 1'b0;
                    bus.ad_oe_o <= 1'b0;
                end
                DATA: begin
                    if (to_cnt != TO_W'(TIMEOUT)) to_cnt <= to_cnt + 1'b1;
                    if (ack_seen) begin
                        state            <= DONE;
                        bus.mst_status_o <= ~{bus.nub_tm1n, bus.nub_tm0n};
                        bus.mstdn_o      <= 1'b1;
                        bus.mst_done_o   <= 1'b1;
                    end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                        state             <= DONE;
                        bus.mst_status_o  <= 2'b11;
                        bus.mst_timeout_o <= 1'b1;
                        bus.mstdn_o       <= 1'b1;
                        bus.mst_done_o    <= 1'b1;
                    end
                end
                DONE: begin
                    state             <= IDLE;
                    bus.mstdn_o       <= 1'b0;
                    bus.mst_done_o    <= 1'b0;
                    bus.mst_timeout_o <= 1'b0;
                    bus.mst_busy_o    <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
